// File: rtl/cmflg_pkg.sv
// cmflg_pkg: gate-select codes for the downstream cmflg cell and the
// state encoding of the bit-serial sequencer that drives it.
`default_nettype none

package cmflg_pkg;

    localparam logic [2:0] BUF  = 3'b000;
    localparam logic [2:0] INV  = 3'b001;
    localparam logic [2:0] AND  = 3'b010;
    localparam logic [2:0] NAND = 3'b011;
    localparam logic [2:0] OR   = 3'b100;
    localparam logic [2:0] NOR  = 3'b101;
    localparam logic [2:0] XOR  = 3'b110;
    localparam logic [2:0] XNOR = 3'b111;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_DRIVE  = 2'd1;
    localparam logic [STATE_W-1:0] ST_SAMPLE = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE   = 2'd3;

    // A single-bit operand still needs a one-bit index register.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmflg_seq.sv
// cmflg_seq: walks an external single-bit cmflg gate across WIDTH operand
// bits (drive one cycle, sample the next) and assembles the bitwise result.
`default_nettype none

module cmflg_seq
    import cmflg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       op_sel,
    output logic             gate_a,
    output logic             gate_b,
    output logic [2:0]       gate_s,
    input  logic             gate_y,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result
);

    localparam int               IDX_W    = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2:0]         sel_reg;
    logic [IDX_W-1:0]   idx;
    logic               last_bit;

    assign last_bit = (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_DRIVE;
            ST_DRIVE:  state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = last_bit ? ST_DONE : ST_DRIVE;
            ST_DONE:   if (res_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state == ST_IDLE);
        busy        = (state == ST_DRIVE) || (state == ST_SAMPLE);
        res_valid   = (state == ST_DONE);
    end

    // Operands are worked from the captured copies so the caller may change
    // op_* as soon as start has been accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sel_reg <= BUF;
            idx     <= '0;
            result  <= '0;
            gate_a  <= 1'b0;
            gate_b  <= 1'b0;
            gate_s  <= BUF;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg   <= op_a;
                        b_reg   <= op_b;
                        sel_reg <= op_sel;
                        idx     <= '0;
                        result  <= '0;
                    end
                end
                ST_DRIVE: begin
                    gate_a <= a_reg[idx];
                    gate_b <= b_reg[idx];
                    gate_s <= sel_reg;
                end
                ST_SAMPLE: begin
                    result[idx] <= gate_y;
                    if (last_bit) begin
                        // Park the gate in its quiescent drive for DONE/IDLE.
                        gate_a <= 1'b0;
                        gate_b <= 1'b0;
                        gate_s <= BUF;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
